// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters,
// with a one-entry registered result buffer carrying the requester tag and an undefined-op flag.
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_ctl,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_ctl,
    output logic [WIDTH-1:0] alu_srca,
    output logic [WIDTH-1:0] alu_srcb,
    output logic [2:0]       alu_ctl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_zero,
    output logic             res_tag,
    output logic             res_err,
    output logic [CNT_W-1:0] op_count
);

    // Encodings the ALU leaves undefined.
    function automatic logic ctl_undefined(input logic [2:0] ctl);
        logic undef_v;
        case (ctl)
            3'b011:  undef_v = 1'b1;
            3'b100:  undef_v = 1'b1;
            3'b101:  undef_v = 1'b1;
            default: undef_v = 1'b0;
        endcase
        return undef_v;
    endfunction

    logic             ptr_r;
    logic             res_valid_r;
    logic [WIDTH-1:0] res_data_r;
    logic             res_zero_r;
    logic             res_tag_r;
    logic             res_err_r;
    logic [CNT_W-1:0] op_count_r;

    logic             can_issue_s;
    logic             gnt0_s;
    logic             gnt1_s;
    logic             gnt_any_s;
    logic             drain_s;

    // The buffer accepts a new op when empty or when it is being drained this cycle.
    assign can_issue_s = ~res_valid_r | res_ready;
    assign drain_s     = res_valid_r & res_ready;

    // Grant selection: a lone requester wins, a tie goes to the pointer side.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (can_issue_s) begin
            if (req0_valid && req1_valid) begin
                if (ptr_r) begin
                    gnt1_s = 1'b1;
                end else begin
                    gnt0_s = 1'b1;
                end
            end else if (req0_valid) begin
                gnt0_s = 1'b1;
            end else if (req1_valid) begin
                gnt1_s = 1'b1;
            end else begin
                gnt0_s = 1'b0;
                gnt1_s = 1'b0;
            end
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    assign gnt_any_s  = gnt0_s | gnt1_s;
    assign req0_ready = gnt0_s;
    assign req1_ready = gnt1_s;

    // ALU operand steering; idle drives all-zero operands and control.
    always_comb begin
        alu_srca = {WIDTH{1'b0}};
        alu_srcb = {WIDTH{1'b0}};
        alu_ctl  = 3'b000;
        if (gnt0_s) begin
            alu_srca = req0_a;
            alu_srcb = req0_b;
            alu_ctl  = req0_ctl;
        end else if (gnt1_s) begin
            alu_srca = req1_a;
            alu_srcb = req1_b;
            alu_ctl  = req1_ctl;
        end else begin
            alu_srca = {WIDTH{1'b0}};
            alu_srcb = {WIDTH{1'b0}};
            alu_ctl  = 3'b000;
        end
    end

    // Round-robin pointer: the loser of this grant wins the next tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_r <= 1'b0;
        end else if (gnt_any_s) begin
            ptr_r <= ~gnt1_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Result buffer: a grant loads (replacing any drained entry), a bare drain only clears valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_valid_r <= 1'b0;
            res_data_r  <= {WIDTH{1'b0}};
            res_zero_r  <= 1'b0;
            res_tag_r   <= 1'b0;
            res_err_r   <= 1'b0;
        end else if (gnt_any_s) begin
            res_valid_r <= 1'b1;
            res_data_r  <= alu_result;
            res_zero_r  <= alu_zero;
            res_tag_r   <= gnt1_s;
            res_err_r   <= ctl_undefined(alu_ctl);
        end else if (drain_s) begin
            res_valid_r <= 1'b0;
        end else begin
            res_valid_r <= res_valid_r;
        end
    end

    // Delivered-result counter, free-running with wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_count_r <= {CNT_W{1'b0}};
        end else if (drain_s) begin
            op_count_r <= op_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            op_count_r <= op_count_r;
        end
    end

    assign res_valid = res_valid_r;
    assign res_data  = res_data_r;
    assign res_zero  = res_zero_r;
    assign res_tag   = res_tag_r;
    assign res_err   = res_err_r;
    assign op_count  = op_count_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a behavioural ALU closes the loop; a second instance
// with a 4-bit counter shares the stimulus to exercise counter wrap.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid, res_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_ctl, req1_ctl;
    logic        req0_ready, req1_ready, res_valid, res_zero, res_tag, res_err;
    logic [31:0] alu_srca, alu_srcb, alu_result, res_data;
    logic [2:0]  alu_ctl;
    logic        alu_zero;
    logic [15:0] op_count;

    logic        r0r4, r1r4, rv4, rz4, rt4, re4;
    logic [31:0] sa4, sb4, ar4, rd4;
    logic [2:0]  ac4;
    logic        az4;
    logic [3:0]  oc4;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] c);
        case (c)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_result = alu_model(alu_srca, alu_srcb, alu_ctl);
    assign alu_zero   = (alu_result == 32'd0);
    assign ar4        = alu_model(sa4, sb4, ac4);
    assign az4        = (ar4 == 32'd0);

    alu_arbiter #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ctl(req0_ctl),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ctl(req1_ctl),
        .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_ctl(alu_ctl),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_zero(res_zero),
        .res_tag(res_tag), .res_err(res_err), .op_count(op_count)
    );

    alu_arbiter #(.WIDTH(32), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(r0r4), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ctl(req0_ctl),
        .req1_valid(req1_valid), .req1_ready(r1r4), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ctl(req1_ctl),
        .alu_srca(sa4), .alu_srcb(sb4), .alu_ctl(ac4),
        .alu_result(ar4), .alu_zero(az4),
        .res_valid(rv4), .res_ready(res_ready), .res_data(rd4), .res_zero(rz4),
        .res_tag(rt4), .res_err(re4), .op_count(oc4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        res_ready = 1'b1;
        req0_valid = 1'b0; req0_a = 32'd0; req0_b = 32'd0; req0_ctl = 3'b000;
        req1_valid = 1'b0; req1_a = 32'd0; req1_b = 32'd0; req1_ctl = 3'b000;
        #12;
        check("rst_valid", {31'd0, res_valid}, 32'd0);
        check("rst_data", res_data, 32'd0);
        check("rst_tag_err", {30'd0, res_tag, res_err}, 32'd0);
        check("rst_count", {16'd0, op_count}, 32'd0);
        reset = 1'b1;
        tick();

        // Test 1: single add 5+7 from requester 0
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_ctl = 3'b010;
        #1;
        check("t1_ready0", {31'd0, req0_ready}, 32'd1);
        check("t1_srca", alu_srca, 32'd5);
        tick();
        req0_valid = 1'b0;
        check("t1_valid", {31'd0, res_valid}, 32'd1);
        check("t1_data", res_data, 32'd12);
        check("t1_zero_tag", {30'd0, res_zero, res_tag}, 32'd0);
        tick();
        check("t1_drained", {31'd0, res_valid}, 32'd0);
        check("t1_hold_data", res_data, 32'd12);
        check("t1_count", {16'd0, op_count}, 32'd1);

        // Test 2: both valid every cycle; pointer is 1 after the test-1 grant
        req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd9; req0_ctl = 3'b110;
        req1_valid = 1'b1; req1_a = 32'h0F; req1_b = 32'hF0; req1_ctl = 3'b001;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t2_ready1", {31'd0, req1_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check("t2_ready0", {31'd0, req0_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
            tick();
            check("t2_valid", {31'd0, res_valid}, 32'd1);
            check("t2_tag", {31'd0, res_tag}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check("t2_data", res_data, (i % 2 == 0) ? 32'hFF : 32'd0);
            check("t2_zero", {31'd0, res_zero}, (i % 2 == 0) ? 32'd0 : 32'd1);
        end
        check("t2_count", {16'd0, op_count}, 32'd4);

        // Test 3: stall three cycles, then release
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t3_readies", {30'd0, req0_ready, req1_ready}, 32'd0);
            tick();
            check("t3_hold", {res_data[30:0], res_valid}, 32'd1);
            check("t3_hold_tag", {30'd0, res_tag, res_zero}, 32'd1);
            check("t3_count", {16'd0, op_count}, 32'd4);
        end
        res_ready = 1'b1;
        #1;
        check("t3_release_r1", {30'd0, req0_ready, req1_ready}, 32'd1);
        tick();
        check("t3_tag", {31'd0, res_tag}, 32'd1);
        check("t3_data", res_data, 32'hFF);
        check("t3_count2", {16'd0, op_count}, 32'd5);

        // Test 4: signed slt and an undefined control
        req0_valid = 1'b0;
        req1_a = 32'hFFFF_FFFD; req1_b = 32'd2; req1_ctl = 3'b111;
        tick();
        check("t4_slt", res_data, 32'd1);
        check("t4_slt_flags", {29'd0, res_tag, res_zero, res_err}, 32'b100);
        req1_a = 32'd5; req1_b = 32'd5; req1_ctl = 3'b100;
        tick();
        check("t4_undef_data", res_data, 32'd0);
        check("t4_undef_flags", {29'd0, res_tag, res_zero, res_err}, 32'b111);
        req1_valid = 1'b0;
        tick();
        check("t4_idle", {30'd0, res_valid, res_err}, 32'b01);
        check("t4_count", {16'd0, op_count}, 32'd8);

        // Test 5: async reset in the middle of a stall
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_ctl = 3'b010;
        res_ready = 1'b0;
        tick();
        check("t5_loaded", {31'd0, res_valid}, 32'd1);
        req1_valid = 1'b1; req1_a = 32'h0F; req1_b = 32'hF0; req1_ctl = 3'b001;
        #3;
        reset = 1'b0;
        #1;
        check("t5_async_valid", {31'd0, res_valid}, 32'd0);
        check("t5_async_count", {16'd0, op_count}, 32'd0);
        check("t5_async_data", res_data, 32'd0);
        res_ready = 1'b1;
        #1;
        check("t5_ptr_zero", {30'd0, req0_ready, req1_ready}, 32'b10);
        reset = 1'b1;
        tick();
        check("t5_first", {res_data[29:0], res_tag, res_valid}, {30'd2, 1'b0, 1'b1});

        // Test 6: counter wrap on the 4-bit instance
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k == 16) check("t6_wrap16", {28'd0, oc4}, 32'd0);
            if (k == 17) check("t6_wrap17", {28'd0, oc4}, 32'd1);
        end
        check("t6_count16", {16'd0, op_count}, 32'd17);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
